// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor.
// One full-adder cell plus a carry flop processes the operands LSB first,
// one bit per clock, behind a start/busy/done handshake. Subtraction is
// A + ~B + 1: the inverted B is loaded and the carry flop is seeded with 1.
// result/cout/ovf are only written on the final bit, so they never show
// partial sums.

module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    // Bit counter only needs to reach WIDTH-1; the exit test stops it there.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-adder sum output.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Full-adder carry output (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  sa_r;
    logic [WIDTH-1:0]  sb_r;
    logic [WIDTH-1:0]  sr_r;
    logic              c_r;
    logic [CW-1:0]     cnt_r;

    logic              accept_s;
    logic              running_s;
    logic              last_bit_s;
    logic              sum_bit_s;
    logic              carry_bit_s;

    // Handshake qualifiers and the single adder cell.
    always_comb begin
        accept_s    = 1'b0;
        running_s   = 1'b0;
        last_bit_s  = 1'b0;
        sum_bit_s   = fa_sum(sa_r[0], sb_r[0], c_r);
        carry_bit_s = fa_carry(sa_r[0], sb_r[0], c_r);
        if (state_r == ST_RUN) begin
            running_s  = 1'b1;
            last_bit_s = (cnt_r == LAST_BIT);
        end else begin
            // start is honoured in IDLE and DONE, never while running.
            accept_s = start;
        end
    end

    // Next-state logic for IDLE -> RUN -> DONE -> (RUN | IDLE).
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_BIT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand shift registers, carry flop, partial-sum register and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_r  <= {WIDTH{1'b0}};
            sb_r  <= {WIDTH{1'b0}};
            sr_r  <= {WIDTH{1'b0}};
            c_r   <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            sa_r  <= a;
            sb_r  <= sub ? ~b : b;
            sr_r  <= {WIDTH{1'b0}};
            c_r   <= sub;
            cnt_r <= {CW{1'b0}};
        end else if (running_s) begin
            sa_r <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r <= {1'b0, sb_r[WIDTH-1:1]};
            sr_r <= {sum_bit_s, sr_r[WIDTH-1:1]};
            c_r  <= carry_bit_s;
            if (!last_bit_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            sa_r  <= sa_r;
            sb_r  <= sb_r;
            sr_r  <= sr_r;
            c_r   <= c_r;
            cnt_r <= cnt_r;
        end
    end

    // Result flags: on the MSB, c_r is the carry into the MSB, so signed
    // overflow is carry-in XOR carry-out of that bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= {WIDTH{1'b0}};
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (last_bit_s) begin
            result <= {sum_bit_s, sr_r[WIDTH-1:1]};
            cout   <= carry_bit_s;
            ovf    <= c_r ^ carry_bit_s;
        end else begin
            result <= result;
            cout   <= cout;
            ovf    <= ovf;
        end
    end

    // Registered handshake outputs, decoded from the next state so they
    // line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_s == ST_RUN);
            done <= (state_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed testbench for serial_addsub (WIDTH=8) with hand-computed vectors.

module tb_serial_addsub;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       ovf;

    int checks;
    int errors;

    serial_addsub #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    // 10 ns clock, rising edges at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!reset && busy && done) begin
            check("busy_done_excl", 32'd1, 32'd0);
        end
    end

    // Wait (bounded) for done; n counts negedges since the accepting edge.
    task automatic wait_done(inout int n);
        while (!done && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
    endtask

    // Count done pulses over a number of cycles.
    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt = cnt + 1;
        end
    endtask

    // One complete operation with latency and result checks.
    task automatic run_op(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        start = 1'b1; sub = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0; sub = ~s; a = ~x; b = ~y;
        n = 1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(n);
        check({tag, "_lat"}, n, 32'd9);
        check({tag, "_res"}, {24'd0, result}, {24'd0, er});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({tag, "_busy_dn"}, {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic       vs [6];
    logic [7:0] vr [6];
    logic       vc [6];
    logic       vo [6];

    initial begin
        int n;
        int cnt;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;

        va = '{8'h35, 8'hFF, 8'h7F, 8'h50, 8'h30, 8'h80};
        vb = '{8'h4A, 8'h01, 8'h01, 8'h30, 8'h50, 8'h01};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vr = '{8'h7F, 8'h00, 8'h80, 8'h20, 8'hE0, 8'h7F};
        vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", {24'd0, result}, 32'd0);
        check("rst_flags", {30'd0, cout, ovf}, 32'd0);
        reset = 1'b0;

        // Directed add/sub vectors.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vs[i], va[i], vb[i], vr[i], vc[i], vo[i]);
        end

        // Start during RUN is ignored.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (2) begin @(negedge clk); n = n + 1; end
        start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        n = n + 1;
        start = 1'b0;
        wait_done(n);
        check("ign_lat", n, 32'd9);
        check("ign_res", {24'd0, result}, 32'h30);
        count_dones(12, cnt);
        check("ign_one_done", cnt, 32'd0);
        check("ign_hold", {24'd0, result}, 32'h30);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        start = 1'b1; sub = 1'b1; a = 8'h55; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_res", {24'd0, result}, 32'd0);
        check("arst_flags", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_dones(12, cnt);
        check("arst_no_done", cnt, 32'd0);
        run_op("post_rst", 1'b0, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0);

        // Start held high: back-to-back operations.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22;
        @(negedge clk);
        sub = 1'b1; a = 8'h05; b = 8'h07;
        n = 1;
        wait_done(n);
        check("b2b_lat1", n, 32'd9);
        check("b2b_res1", {24'd0, result}, 32'h33);
        check("b2b_cout1", {31'd0, cout}, 32'd0);
        @(negedge clk);
        n = 1;
        wait_done(n);
        start = 1'b0;
        check("b2b_gap", n, 32'd9);
        check("b2b_res2", {24'd0, result}, 32'hFE);
        check("b2b_cout2", {31'd0, cout}, 32'd0);
        check("b2b_ovf2", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        check("b2b_idle", {30'd0, busy, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial two's-complement adder/subtractor that computes A+B or A−B one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It is the sequential counterpart to the combinational gate-level full adder in the gate library. It trades width-proportional latency for a single adder cell. It sits behind a start/done handshake so a controller or testbench can issue back-to-back operations.

## Interface
- WIDTH, default 8, operand and result width in bits (≥2).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; returns block to IDLE.
- start  in  1  request; accepted only when busy=0.
- sub  in  1  0 = add, 1 = subtract (A−B); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when result is updated.
- result  out  WIDTH  last completed sum/difference (mod 2^WIDTH).
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  signed overflow of last completed operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1 → load shift reg SA←a, SB←(sub ? ~b : b); carry flop C←sub; bit counter←0; go RUN.
- RUN, each cycle: s = SA[0]^SB[0]^C; c' = majority(SA[0],SB[0],C); s shifts into MSB of internal shift reg SR; SA, SB shift right; C←c'; counter+1.
- On the bit with counter = WIDTH−1: latch Cmsb_in = C (carry into MSB) for overflow. Update result←{s, SR[WIDTH−1:1]}, cout←c', ovf←Cmsb_in^c'. Go DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted as in IDLE and goes straight to RUN.
  - Otherwise go to IDLE.
- start while RUN is ignored: no queuing, and operands are not resampled.
- a, b, sub are don't-care except in the accepting cycle.
- result, cout and ovf hold their values until the next completion; they never show partial values.
- Counter is ceil(log2(WIDTH)) bits wide; no wrap occurs because the exit condition is counter = WIDTH−1.

## Timing
- Reset (async assert, sync to clk on deassert by the surrounding design):
  - state = IDLE.
  - busy, done, result, cout and ovf = 0.
  - Internal regs cleared.
- Reset mid-RUN aborts the operation. No done pulse is produced and outputs return to 0.
- Edge E0 samples start=1 (state IDLE or DONE).
- busy=1 from after E0 through edge E_WIDTH.
- At edge E_WIDTH: result, cout and ovf are updated and state becomes DONE.
- done=1 between E_WIDTH and E_WIDTH+1; busy=0 in that cycle.
- Latency: start to done = WIDTH+1 cycles.
- Back-to-back throughput: one operation per WIDTH+1 cycles.
- busy and done are never simultaneously high.

## Test plan
- WIDTH=8, add 0x35+0x4A → done exactly 9 cycles after start; result=0x7F, cout=0, ovf=0.
- Add 0xFF+0x01 → result=0x00, cout=1, ovf=0. Add 0x7F+0x01 → result=0x80, cout=0, ovf=1.
- Sub 0x50−0x30 → 0x20, cout=1, ovf=0. Sub 0x30−0x50 → 0xE0, cout=0, ovf=0. Sub 0x80−0x01 → 0x7F, cout=1, ovf=1.
- Pulse start with new operands (0x01+0x01) at cycle 3 of RUN for 0x10+0x20 → that start is ignored. Single done with result 0x30; result holds 0x30 until the next start.
- Assert reset at cycle 4 of RUN → busy, done, result, cout and ovf go to 0 immediately (async). No done follows. The next start completes normally.
- Start held high continuously with 0x11+0x22 then 0x05−0x07 → done pulses spaced 9 cycles apart; results 0x33, then 0xFE with cout=0.
